gate_truth_table_checker: RTL and testbench
===========================================

# gate_truth_table_checker

- Self-checking sequential harness for 2-input logic-gate models.
- Drives every input combination onto a shared `a`/`b` pair, which fans out to up to `NUM_MODELS` gate implementations (gate-level, dataflow, behavioral).
- After a settle interval it samples their outputs and compares each against an expected truth table.
- Reports per-model failures, a mismatch count and a pass flag; it is the receiving/checking end of the stimulus/response interface that the gate models present.

## Interface

Parameters:
- `TRUTH_TABLE`, default `4'b1000`: expected output; bit `{a,b}` is the expected `y`. The default is AND.
- `NUM_MODELS`, default `3`: number of gate outputs checked in parallel. Range 1..8.
- `SETTLE_CYCLES`, default `2`: cycles to hold each vector before sampling. Legal range is ≥1.

Ports:
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a sweep. Accepted only in IDLE or DONE.
- `a`, output, 1: stimulus input A to all models (registered).
- `b`, output, 1: stimulus input B to all models (registered).
- `y_in`, input, `NUM_MODELS`: model outputs; bit i belongs to model i.
- `busy`, output, 1: high while a sweep is in progress.
- `done`, output, 1: level; high from sweep completion until the next accepted `start` or reset.
- `pass`, output, 1: valid only while `done`=1; 1 iff `err_count`==0.
- `err_count`, output, 4: total mismatches in the sweep. Saturates at 15.
- `fail_vec`, output, `NUM_MODELS`: sticky per-model failure flags, cleared on `start`.
- `first_fail_idx`, output, 2: vector index `{a,b}` of the first mismatch. Valid when `err_count`≠0.

## Operation

- State machine states:
  - IDLE
  - SETTLE
  - SAMPLE
  - DONE
- Internal registers:
  - 2-bit vector index `idx`.
  - Settle down-counter `cnt`, width clog2(`SETTLE_CYCLES`+1).
- Reset (async, immediate): state=IDLE, `idx`=0, `cnt`=0.
- Reset values of outputs:
  - `a`=0, `b`=0
  - `busy`=0, `done`=0, `pass`=0
  - `err_count`=0, `fail_vec`=0, `first_fail_idx`=0
- Reset asserted mid-sweep aborts it with no partial result retained.
- IDLE or DONE with `start`=1:
  - state→SETTLE, `idx`=0, `a`=0, `b`=0, `cnt`=`SETTLE_CYCLES`−1.
  - `busy`=1, `done`=0, `pass`=0.
  - `err_count`, `fail_vec` and `first_fail_idx` are cleared.
- SETTLE:
  - If `cnt`==0, state→SAMPLE.
  - Otherwise `cnt` decrements.
  - `a`/`b` are held.
- SAMPLE (exactly one cycle): for each model i, a mismatch exists when `y_in[i]` != `TRUTH_TABLE[idx]`.
  - Each mismatching model sets `fail_vec[i]`.
  - `err_count` increases by the number of mismatches this cycle (popcount), saturating at 15.
  - If `err_count` was 0 and at least one mismatch occurs, `first_fail_idx` is set to `idx`.
  - If `idx`==3: state→DONE, `busy`=0, `done`=1, and `pass` = (final `err_count`==0).
  - Otherwise: `idx`+1, `{a,b}` = new `idx`, `cnt` reloaded to `SETTLE_CYCLES`−1, state→SETTLE.
- Vector order is `{a,b}` = 00, 01, 10, 11. `a` is `idx[1]`, `b` is `idx[0]`.
- `start` asserted while `busy`=1 is ignored and does not restart the sweep.
- DONE holds all results stable indefinitely.
- `start` in DONE begins a fresh sweep; results are cleared on that same edge.

## Timing

- Each vector takes `SETTLE_CYCLES` cycles in SETTLE plus 1 cycle in SAMPLE.
- The vector changes on the edge that leaves SAMPLE.
- Start-to-done latency: `done` rises on the 4×(`SETTLE_CYCLES`+1)-th rising edge after the edge that accepts `start`. With the default, that is 12 edges.
- Model outputs must be stable by the final SETTLE cycle. `y_in` is sampled on the edge at the end of SAMPLE, i.e. `SETTLE_CYCLES`+1 cycles after `a`/`b` change.
- `busy` and `done` are never high simultaneously.
- Exactly one of IDLE/DONE/`busy` holds at any time.
- The results update on the SAMPLE edge. On the final vector, `pass` is computed from the updated count on that same edge.

## Test plan

1. **Clean sweep with three correct AND models** (defaults).
   - Stimulus: pulse `start` for 1 cycle.
   - Required: `a`/`b` step 00→01→10→11, each held 3 cycles; `done`=1 exactly 12 edges later; `pass`=1, `err_count`=0, `fail_vec`=000.
2. **Model 2 stuck at 1.**
   - Required: mismatches at idx 0, 1 and 2; `err_count`=3, `fail_vec`=100, `first_fail_idx`=0, `pass`=0.
3. **Model 0 replaced by OR** (outputs for 00..11 are 0,1,1,1).
   - Required: `err_count`=2, `fail_vec`=001, `first_fail_idx`=1.
4. **Saturation.**
   - Stimulus: `NUM_MODELS`=8, all models inverted.
   - Required: 8 mismatches per vector = 32 total, so `err_count`=15 and `fail_vec`=8'hFF.
5. **Start while busy, then restart.**
   - Stimulus: pulse `start` at cycle 5 of a sweep.
   - Required: the sweep continues unchanged and `done` still rises at edge 12.
   - Then pulse `start` in DONE. Required: `done`=0, `err_count`=0, `fail_vec` cleared on that edge.
6. **Reset mid-sweep.**
   - Stimulus: assert `rst_n`=0 asynchronously (between edges) during the SETTLE of vector 2.
   - Required: all outputs go to reset values immediately without waiting for a clock edge.
   - Stimulus: after release, `start`. Required: a full sweep from `{a,b}`=00.

Source files
------------

// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker: sweeps the four {a,b} vectors into up to NUM_MODELS
// 2-input gate models, samples their outputs after a settle interval and
// compares each one against TRUTH_TABLE. It reports per-model failure flags,
// a saturating mismatch count, the first failing vector and a pass flag.
module gate_truth_table_checker #(
    parameter logic [3:0] TRUTH_TABLE   = 4'b1000,
    parameter int         NUM_MODELS    = 3,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  a,
    output logic                  b,
    input  logic [NUM_MODELS-1:0] y_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [3:0]            err_count,
    output logic [NUM_MODELS-1:0] fail_vec,
    output logic [1:0]            first_fail_idx
);

    localparam int              CNT_W      = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    a_q, a_d, b_q, b_d;
    logic                    busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [3:0]              err_q, err_d;
    logic [NUM_MODELS-1:0]   fail_q, fail_d;
    logic [1:0]              ffi_q, ffi_d;

    logic [NUM_MODELS-1:0]   mism;
    logic [3:0]              n_mism;
    logic [4:0]              err_sum;
    logic [3:0]              err_sat;

    // Per-model mismatch against the expected bit for the current vector,
    // its popcount, and the saturated running total.
    always_comb begin
        mism   = y_in ^ {NUM_MODELS{TRUTH_TABLE[idx_q]}};
        n_mism = 4'd0;
        for (int i = 0; i < NUM_MODELS; i++) begin
            n_mism = n_mism + 4'(mism[i]);
        end
        err_sum = {1'b0, err_q} + {1'b0, n_mism};
        err_sat = (err_sum > 5'd15) ? 4'hF : err_sum[3:0];
    end

    // Sweep sequencing: next state and all registered outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;
        ffi_d   = ffi_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    idx_d   = 2'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    cnt_d   = CNT_RELOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 4'd0;
                    fail_d  = '0;
                    ffi_d   = 2'd0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_SAMPLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_SAMPLE: begin
                fail_d = fail_q | mism;
                err_d  = err_sat;
                if (err_q == 4'd0 && n_mism != 4'd0) ffi_d = idx_q;
                if (idx_q == 2'd3) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_sat == 4'd0);
                end else begin
                    idx_d   = idx_q + 2'd1;
                    a_d     = idx_d[1];
                    b_d     = idx_d[0];
                    cnt_d   = CNT_RELOAD;
                    state_d = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 4'd0;
            fail_q  <= '0;
            ffi_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            ffi_q   <= ffi_d;
        end
    end

    assign a              = a_q;
    assign b              = b_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign fail_vec       = fail_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: a 3-model instance with configurable
// gate models and an 8-model instance whose models are all NAND (inverted AND).
module tb_gate_truth_table_checker;

    localparam int         S    = 2;
    localparam int         P    = S + 1;
    localparam logic [3:0] TT   = 4'b1000;
    localparam int         MAXE = 4 * P;

    // gate model kinds
    localparam int G_AND = 0, G_OR = 1, G_ONE = 2, G_NAND = 3;

    logic clk = 1'b0;
    logic rst_n, start;

    logic       a3, b3, busy3, done3, pass3;
    logic [2:0] y3, fv3;
    logic [3:0] err3;
    logic [1:0] ffi3;

    logic       a8, b8, busy8, done8, pass8;
    logic [7:0] y8, fv8;
    logic [3:0] err8;
    logic [1:0] ffi8;

    int md3[8];
    int md8[8];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gate_truth_table_checker #(.TRUTH_TABLE(TT), .NUM_MODELS(3), .SETTLE_CYCLES(S)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a3), .b(b3), .y_in(y3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_vec(fv3), .first_fail_idx(ffi3));

    gate_truth_table_checker #(.TRUTH_TABLE(TT), .NUM_MODELS(8), .SETTLE_CYCLES(S)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a8), .b(b8), .y_in(y8),
        .busy(busy8), .done(done8), .pass(pass8), .err_count(err8),
        .fail_vec(fv8), .first_fail_idx(ffi8));

    function automatic logic gate(input int m, input logic x, input logic z);
        case (m)
            G_AND:   return x & z;
            G_OR:    return x | z;
            G_ONE:   return 1'b1;
            default: return ~(x & z);
        endcase
    endfunction

    // gate models under test
    always_comb begin
        y3 = '0;
        y8 = '0;
        for (int i = 0; i < 3; i++) y3[i] = gate(md3[i], a3, b3);
        for (int i = 0; i < 8; i++) y8[i] = gate(md8[i], a8, b8);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A sweep is tracked only as "edges since the accepting edge" plus the
    // gate kinds captured at acceptance; outputs are derived arithmetically.
    bit m_started;
    int m_e;
    int m_md3[8];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0;
            m_e       <= 0;
        end else if (start && (!m_started || m_e >= MAXE)) begin
            m_started <= 1'b1;
            m_e       <= 0;
            m_md3     <= md3;
        end else if (m_started && m_e < MAXE) begin
            m_e <= m_e + 1;
        end
    end

    typedef struct {
        int a, b, busy, done, pass, err, fv, ffi;
    } exp_t;

    function automatic exp_t expect_out(input bit st, input int e, input int nm, input int md[8]);
        exp_t r;
        int   tot, v;
        r = '{0, 0, 0, 0, 0, 0, 0, 0};
        if (!st) return r;
        v      = (e / P > 3) ? 3 : e / P;
        r.a    = v / 2;
        r.b    = v % 2;
        r.done = (e >= MAXE) ? 1 : 0;
        r.busy = 1 - r.done;
        tot    = 0;
        for (int vv = 0; vv < 4; vv++) begin
            if ((vv + 1) * P <= e) begin
                int n = 0;
                for (int i = 0; i < nm; i++) begin
                    if (gate(md[i], vv[1], vv[0]) != TT[vv]) begin
                        n++;
                        r.fv = r.fv | (1 << i);
                    end
                end
                if (n > 0 && tot == 0) r.ffi = vv;
                tot += n;
            end
        end
        r.err  = (tot > 15) ? 15 : tot;
        r.pass = (r.done == 1 && tot == 0) ? 1 : 0;
        return r;
    endfunction

    // cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        exp_t e3, e8;
        e3 = expect_out(m_started, m_e, 3, m_md3);
        e8 = expect_out(m_started, m_e, 8, md8);
        chk("d3.a", int'(a3), e3.a);           chk("d3.b", int'(b3), e3.b);
        chk("d3.busy", int'(busy3), e3.busy);  chk("d3.done", int'(done3), e3.done);
        chk("d3.pass", int'(pass3), e3.pass);  chk("d3.err", int'(err3), e3.err);
        chk("d3.fail_vec", int'(fv3), e3.fv);  chk("d3.ffi", int'(ffi3), e3.ffi);
        chk("d8.a", int'(a8), e8.a);           chk("d8.b", int'(b8), e8.b);
        chk("d8.busy", int'(busy8), e8.busy);  chk("d8.done", int'(done8), e8.done);
        chk("d8.pass", int'(pass8), e8.pass);  chk("d8.err", int'(err8), e8.err);
        chk("d8.fail_vec", int'(fv8), e8.fv);  chk("d8.ffi", int'(ffi8), e8.ffi);
    end

    // ---------------- stimulus ----------------
    // Pulse start, check results cleared on the accepting edge, then count
    // edges until done (bounded). Optionally re-pulse start at edge bp.
    task automatic run_sweep(input string tag, input int bp);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, ".clr_done"}, int'(done3), 0);
        chk({tag, ".clr_err"},  int'(err3), 0);
        chk({tag, ".clr_fv"},   int'(fv3), 0);
        n = 0;
        repeat (MAXE + 8) begin
            @(posedge clk);
            #1;
            n++;
            start = (n == bp);
            if (done3) break;
        end
        start = 1'b0;
        chk({tag, ".done_latency"}, n, 12);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            md3[i] = G_AND;
            md8[i] = G_NAND;
        end
        repeat (2) @(negedge clk);
        chk("rst.busy", int'(busy3), 0);
        chk("rst.err", int'(err3), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle.done", int'(done3), 0);

        // 1: clean AND sweep
        run_sweep("t1", -1);
        chk("t1.pass", int'(pass3), 1);
        chk("t1.err", int'(err3), 0);
        chk("t1.fv", int'(fv3), 0);
        chk("t1.ab", int'({a3, b3}), 3);
        // 4: eight inverted models saturate
        chk("t4.err", int'(err8), 15);
        chk("t4.fv", int'(fv8), 8'hFF);
        chk("t4.pass", int'(pass8), 0);

        // 2: model 2 stuck at 1 (restart from DONE)
        md3[2] = G_ONE;
        run_sweep("t2", -1);
        chk("t2.err", int'(err3), 3);
        chk("t2.fv", int'(fv3), 3'b100);
        chk("t2.ffi", int'(ffi3), 0);
        chk("t2.pass", int'(pass3), 0);

        // 3: model 0 is OR
        md3[2] = G_AND;
        md3[0] = G_OR;
        run_sweep("t3", -1);
        chk("t3.err", int'(err3), 2);
        chk("t3.fv", int'(fv3), 3'b001);
        chk("t3.ffi", int'(ffi3), 1);

        // 5: start while busy is ignored
        md3[0] = G_AND;
        run_sweep("t5", 5);
        chk("t5.pass", int'(pass3), 1);
        run_sweep("t5r", -1);
        chk("t5r.pass", int'(pass3), 1);

        // 6: asynchronous reset during SETTLE of vector 2
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        chk("t6.pre_a", int'(a3), 1);
        rst_n = 1'b0;
        #1;
        chk("t6.a", int'(a3), 0);
        chk("t6.busy", int'(busy3), 0);
        chk("t6.done", int'(done3), 0);
        chk("t6.busy8", int'(busy8), 0);
        chk("t6.err8", int'(err8), 0);
        chk("t6.fv8", int'(fv8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep("t6s", -1);
        chk("t6s.pass", int'(pass3), 1);
        chk("t6s.err8", int'(err8), 15);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
